io_responder: RTL and testbench

IO_RESPONDER -- requirements
Module: io_responder

---
 rtl/io_responder.sv | 124 ++++++++++++
 tb/tb_io_responder.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/io_responder.sv
// io_responder: CPU-facing LED output register and debounced switch input register.
//   - LED register is written when led_cs is high and io_addr[7:0] matches LED_ADDR.
//   - Switch levels pass through a 2-flop synchronizer and then into sw_stable.
//   - io_rdata returns sw_stable combinationally when switch_cs is high and
//     io_addr[7:0] matches SW_ADDR, otherwise zero. Reads have no side effects.
// Build option: define IO_DEBOUNCE_EN to compile in the word-wide debounce filter.
// Without it, sw_stable follows the synchronizer output every cycle and
// DEBOUNCE_CYCLES is ignored.
module io_responder #(
  parameter int unsigned DEBOUNCE_CYCLES = 20000,
  parameter logic [7:0]  LED_ADDR        = 8'h60,
  parameter logic [7:0]  SW_ADDR         = 8'h70
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        led_cs,
  input  logic        switch_cs,
  input  logic [31:0] io_addr,
  input  logic [23:0] io_wdata,
  output logic [23:0] io_rdata,
  input  logic [23:0] switch_in,
  output logic [23:0] led_out
);

  // Only the low address byte takes part in decode.
  logic unused_addr_hi;
  assign unused_addr_hi = ^io_addr[31:8];

  logic        led_wr;
  logic        sw_rd;
  logic [23:0] led_q, led_d;
  logic [23:0] sw_s1_q;
  logic [23:0] sw_s2_q;
  logic [23:0] sw_stable_q, sw_stable_d;

  assign led_wr = led_cs && (io_addr[7:0] == LED_ADDR);
  assign sw_rd  = switch_cs && (io_addr[7:0] == SW_ADDR);

  // Read mux: accepted switch word when addressed, zero otherwise.
  always_comb begin
    io_rdata = 24'h0;
    if (sw_rd) begin
      io_rdata = sw_stable_q;
    end
  end

  // LED register next state: load on a decoded write, otherwise hold.
  always_comb begin
    led_d = led_q;
    if (led_wr) begin
      led_d = io_wdata;
    end
  end

  // LED register and switch synchronizer.
  always_ff @(posedge clock) begin
    if (reset) begin
      led_q   <= 24'h0;
      sw_s1_q <= 24'h0;
      sw_s2_q <= 24'h0;
    end else begin
      led_q   <= led_d;
      sw_s1_q <= switch_in;
      sw_s2_q <= sw_s1_q;
    end
  end

  assign led_out = led_q;

`ifdef IO_DEBOUNCE_EN
  // Counter sized to reach DEBOUNCE_CYCLES-1; it saturates there so a long
  // stable period keeps refreshing sw_stable without wrapping.
  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [23:0]      sw_cand_q, sw_cand_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Debounce next state: any bit change restarts the count for the whole word.
  always_comb begin
    sw_cand_d   = sw_cand_q;
    cnt_d       = cnt_q;
    sw_stable_d = sw_stable_q;
    if (sw_s2_q != sw_cand_q) begin
      sw_cand_d = sw_s2_q;
      cnt_d     = '0;
    end else if (cnt_q == CNT_MAX) begin
      sw_stable_d = sw_cand_q;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Debounce state registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      sw_cand_q   <= 24'h0;
      cnt_q       <= '0;
      sw_stable_q <= 24'h0;
    end else begin
      sw_cand_q   <= sw_cand_d;
      cnt_q       <= cnt_d;
      sw_stable_q <= sw_stable_d;
    end
  end
`else
  localparam int unsigned unused_debounce_cycles = DEBOUNCE_CYCLES;

  // No filtering: accept the synchronized level every cycle.
  always_comb begin
    sw_stable_d = sw_s2_q;
  end

  // Accepted switch register.
  always_ff @(posedge clock) begin
    if (reset) begin
      sw_stable_q <= 24'h0;
    end else begin
      sw_stable_q <= sw_stable_d;
    end
  end
`endif

endmodule

// File: tb/tb_io_responder.sv
// Directed bench for io_responder with DEBOUNCE_CYCLES=4. A second instance
// shares one address for LED and switch so a simultaneous write+read can be
// decoded by a single io_addr value.
module tb_io_responder;

`ifdef IO_DEBOUNCE_EN
  localparam int LAT = 4 + 3;
`else
  localparam int LAT = 3;
`endif

  logic        clock;
  logic        reset;
  logic        led_cs;
  logic        switch_cs;
  logic [31:0] io_addr;
  logic [23:0] io_wdata;
  logic [23:0] switch_in;
  logic [23:0] io_rdata, led_out;
  logic [23:0] io_rdata2, led_out2;

  int n_cmp = 0;
  int n_err = 0;

  io_responder #(.DEBOUNCE_CYCLES(4), .LED_ADDR(8'h60), .SW_ADDR(8'h70)) dut (
    .clock(clock), .reset(reset), .led_cs(led_cs), .switch_cs(switch_cs),
    .io_addr(io_addr), .io_wdata(io_wdata), .io_rdata(io_rdata),
    .switch_in(switch_in), .led_out(led_out)
  );

  io_responder #(.DEBOUNCE_CYCLES(4), .LED_ADDR(8'h70), .SW_ADDR(8'h70)) dut_shared (
    .clock(clock), .reset(reset), .led_cs(led_cs), .switch_cs(switch_cs),
    .io_addr(io_addr), .io_wdata(io_wdata), .io_rdata(io_rdata2),
    .switch_in(switch_in), .led_out(led_out2)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [23:0] obs, input logic [23:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset = 1'b1; led_cs = 1'b0; switch_cs = 1'b0;
    io_addr = 32'h0; io_wdata = 24'h0; switch_in = 24'h0;
    tick(); tick();
    reset = 1'b0; switch_cs = 1'b1; io_addr = 32'hFFFFFC70;
    #1;
    check("rst_led", led_out, 24'h0);
    check("rst_rdata", io_rdata, 24'h0);

    // LED write, then non-matching address, then chip select low
    led_cs = 1'b1; io_addr = 32'hFFFFFC60; io_wdata = 24'hA5A5A5;
    #1;
    check("led_before_edge", led_out, 24'h0);
    tick();
    check("led_write", led_out, 24'hA5A5A5);
    io_addr = 32'hFFFFFC64; io_wdata = 24'h0;
    tick();
    check("led_addr_miss", led_out, 24'hA5A5A5);
    led_cs = 1'b0; io_addr = 32'hFFFFFC60; io_wdata = 24'h123123;
    tick();
    check("led_cs_low", led_out, 24'hA5A5A5);

    // switch acceptance latency
    switch_cs = 1'b1; io_addr = 32'hFFFFFC70; switch_in = 24'h00F00F;
    for (int i = 1; i <= LAT; i++) begin
      tick();
      check((i < LAT) ? "sw_early" : "sw_accept", io_rdata, (i < LAT) ? 24'h0 : 24'h00F00F);
    end
    switch_cs = 1'b0;
    #1 check("rd_cs_low", io_rdata, 24'h0);
    switch_cs = 1'b1; io_addr = 32'hFFFFFC74;
    #1 check("rd_addr_miss", io_rdata, 24'h0);
    io_addr = 32'hFFFFFC70;
    #1 check("rd_again", io_rdata, 24'h00F00F);

    switch_in = 24'h123456;
    for (int i = 1; i <= LAT; i++) begin
      tick();
      check((i < LAT) ? "sw2_early" : "sw2_accept", io_rdata, (i < LAT) ? 24'h00F00F : 24'h123456);
    end

    // glitch rejection from a zero baseline
    switch_in = 24'h0;
    repeat (LAT) tick();
    check("sw_zero", io_rdata, 24'h0);
    switch_in = 24'h000001;
    tick(); tick();
    switch_in = 24'h0;
`ifdef IO_DEBOUNCE_EN
    for (int i = 0; i < 12; i++) begin
      tick();
      check("glitch_blocked", io_rdata, 24'h0);
    end
`else
    tick();
    check("glitch_pass", io_rdata, 24'h000001);
    tick(); tick();
    check("glitch_gone", io_rdata, 24'h0);
`endif

    // simultaneous LED write and switch read on the shared-address instance
    switch_in = 24'hABCDEF;
    repeat (LAT) tick();
    check("sw3_accept", io_rdata, 24'hABCDEF);
    check("shared_led_pre", led_out2, 24'h0);
    led_cs = 1'b1; io_wdata = 24'h5A5A5A; io_addr = 32'hFFFFFC70;
    #1;
    check("both_rdata_shared", io_rdata2, 24'hABCDEF);
    check("both_rdata_main", io_rdata, 24'hABCDEF);
    tick();
    led_cs = 1'b0;
    check("both_led_shared", led_out2, 24'h5A5A5A);
    check("both_led_main_hold", led_out, 24'hA5A5A5);
    check("both_rdata_after", io_rdata2, 24'hABCDEF);

    // reset during debounce count and during a LED write
    switch_in = 24'h111111;
    repeat (4) tick();
    reset = 1'b1; led_cs = 1'b1; io_addr = 32'hFFFFFC60; io_wdata = 24'hFFFFFF;
    tick();
    reset = 1'b0; led_cs = 1'b0; io_addr = 32'hFFFFFC70;
    #1;
    check("rst2_led", led_out, 24'h0);
    check("rst2_led_shared", led_out2, 24'h0);
    check("rst2_rdata", io_rdata, 24'h0);
    for (int i = 1; i <= LAT; i++) begin
      tick();
      check((i < LAT) ? "rst2_sw_early" : "rst2_sw_accept", io_rdata, (i < LAT) ? 24'h0 : 24'h111111);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
